// File: rtl/writeback_regfile_pkg.sv
// rtl/writeback_regfile_pkg.sv - shared sizes, types and write-back source select
package writeback_regfile_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_COUNT  = 8;
  localparam int DATA_W     = 16;
  localparam int PH_WB      = 4;
  localparam int PH_W       = 5;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [PH_W-1:0]       phase_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  function automatic word_t wb_select(input wb_src_e src, input word_t alu_result,
                                      input word_t load_data);
    return (src == WB_SRC_MEM) ? load_data : alu_result;
  endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - MEM/WB inputs, decode read ports and debug outputs
interface writeback_regfile_if;
  import writeback_regfile_pkg::*;

  phase_t    phasecounter;
  logic      MemtoReg;
  logic      RegWrite;
  word_t     ALUResult;
  word_t     data;
  reg_addr_t des;
  reg_addr_t ra1;
  reg_addr_t ra2;
  word_t     rd1;
  word_t     rd2;
  word_t     wb_value;
  logic      wb_valid;
  word_t     wb_count;

  modport master (
    output phasecounter, MemtoReg, RegWrite, ALUResult, data, des, ra1, ra2,
    input  rd1, rd2, wb_value, wb_valid, wb_count
  );

  modport slave (
    input  phasecounter, MemtoReg, RegWrite, ALUResult, data, des, ra1, ra2,
    output rd1, rd2, wb_value, wb_valid, wb_count
  );

endinterface

// File: rtl/writeback_regfile_regfile_8x16.sv
// rtl/writeback_regfile_regfile_8x16.sv - 8x16 storage, one write port, two async read ports
module regfile_8x16
  import writeback_regfile_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      we,
  input  reg_addr_t waddr,
  input  word_t     wdata,
  input  reg_addr_t ra1,
  input  reg_addr_t ra2,
  output word_t     rd1,
  output word_t     rd2
);

  word_t mem [REG_COUNT];

  // r0 is ordinary storage; there is no hardwired zero register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - write-back select, commit, counters; WB_BYPASS_EN adds same-cycle read bypass
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  writeback_regfile_if.slave  bus
);

  word_t wb_value;
  logic  commit;
  word_t stored_rd1;
  word_t stored_rd2;
  logic  wb_valid_q;
  word_t wb_count_q;

  // Only the write-back phase bit matters; the rest of the phase vector is ignored.
  logic unused_phase_bits;
  assign unused_phase_bits = &{1'b0, bus.phasecounter[PH_WB-1:0]};

  assign wb_value = wb_select(wb_src_e'(bus.MemtoReg), bus.ALUResult, bus.data);
  assign commit   = reset && bus.phasecounter[PH_WB] && bus.RegWrite;

  regfile_8x16 u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (commit),
    .waddr (bus.des),
    .wdata (wb_value),
    .ra1   (bus.ra1),
    .ra2   (bus.ra2),
    .rd1   (stored_rd1),
    .rd2   (stored_rd2)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_count_q <= '0;
    end else begin
      wb_valid_q <= commit;
      if (commit) begin
        wb_count_q <= wb_count_q + 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Write-through so decode sees the value being committed this cycle.
  assign bus.rd1 = (commit && (bus.ra1 == bus.des)) ? wb_value : stored_rd1;
  assign bus.rd2 = (commit && (bus.ra2 == bus.des)) ? wb_value : stored_rd2;
`else
  assign bus.rd1 = stored_rd1;
  assign bus.rd2 = stored_rd2;
`endif

  assign bus.wb_value = wb_value;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed vector table plus reset, bypass and wrap sequences
module tb_writeback_regfile;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;

  writeback_regfile_if bus ();

  writeback_regfile dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  ph;
    logic        rw;
    logic        m2r;
    logic [15:0] alu;
    logic [15:0] dat;
    logic [2:0]  des;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [15:0] e_rd1;
    logic [15:0] e_rd2;
    logic        e_valid;
    logic [15:0] e_count;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] ph, input logic rw, input logic m2r,
                       input logic [15:0] alu, input logic [15:0] dat, input logic [2:0] des,
                       input logic [2:0] ra1, input logic [2:0] ra2);
    bus.phasecounter = ph;
    bus.RegWrite     = rw;
    bus.MemtoReg     = m2r;
    bus.ALUResult    = alu;
    bus.data         = dat;
    bus.des          = des;
    bus.ra1          = ra1;
    bus.ra2          = ra2;
  endtask

  task automatic go_idle();
    bus.phasecounter = 5'b00001;
    bus.RegWrite     = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_byp;
    //            ph        rw    m2r   alu       dat       des   ra1   ra2   rd1       rd2       v     count
    vt[0] = '{5'b00001, 1'b0, 1'b0, 16'h9999, 16'h0000, 3'd2, 3'd0, 3'd7, 16'h0000, 16'h0000, 1'b0, 16'd0};
    vt[1] = '{5'b10000, 1'b1, 1'b0, 16'h1234, 16'h0000, 3'd5, 3'd5, 3'd0, 16'h1234, 16'h0000, 1'b1, 16'd1};
    vt[2] = '{5'b10000, 1'b1, 1'b1, 16'h1111, 16'hBEEF, 3'd0, 3'd0, 3'd5, 16'hBEEF, 16'h1234, 1'b1, 16'd2};
    vt[3] = '{5'b01000, 1'b1, 1'b0, 16'h7777, 16'h0000, 3'd0, 3'd0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b0, 16'd2};
    vt[4] = '{5'b10000, 1'b0, 1'b0, 16'h5555, 16'h0000, 3'd3, 3'd3, 3'd5, 16'h0000, 16'h1234, 1'b0, 16'd2};
    vt[5] = '{5'b11111, 1'b1, 1'b0, 16'h0001, 16'h2222, 3'd7, 3'd7, 3'd7, 16'h0001, 16'h0001, 1'b1, 16'd3};
    vt[6] = '{5'b01111, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 3'd1, 3'd1, 3'd7, 16'h0000, 16'h0001, 1'b0, 16'd3};
    vt[7] = '{5'b10000, 1'b1, 1'b1, 16'h3333, 16'h8000, 3'd7, 3'd7, 3'd0, 16'h8000, 16'hBEEF, 1'b1, 16'd4};
    vt[8] = '{5'b00100, 1'b1, 1'b0, 16'h4444, 16'h0000, 3'd6, 3'd6, 3'd5, 16'h0000, 16'h1234, 1'b0, 16'd4};

    drive(5'b00001, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd0);
    repeat (2) @(posedge clock);
    #1;
    for (int a = 0; a < 8; a++) begin
      bus.ra1 = 3'(a);
      bus.ra2 = 3'(7 - a);
      #1;
      check($sformatf("reset_rd1[%0d]", a), bus.rd1, 16'h0000);
      check($sformatf("reset_rd2[%0d]", 7 - a), bus.rd2, 16'h0000);
    end
    check("reset_valid", {15'd0, bus.wb_valid}, 16'd0);
    check("reset_count", bus.wb_count, 16'd0);

    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      drive(vt[i].ph, vt[i].rw, vt[i].m2r, vt[i].alu, vt[i].dat, vt[i].des, vt[i].ra1, vt[i].ra2);
      #1;
      check($sformatf("v%0d_wb_value", i), bus.wb_value, vt[i].m2r ? vt[i].dat : vt[i].alu);
      @(posedge clock);
      #1;
      go_idle();
      #1;
      check($sformatf("v%0d_rd1", i), bus.rd1, vt[i].e_rd1);
      check($sformatf("v%0d_rd2", i), bus.rd2, vt[i].e_rd2);
      check($sformatf("v%0d_valid", i), {15'd0, bus.wb_valid}, {15'd0, vt[i].e_valid});
      check($sformatf("v%0d_count", i), bus.wb_count, vt[i].e_count);
    end

    // Same-cycle read of the register being committed.
    @(negedge clock);
    drive(5'b10000, 1'b1, 1'b0, 16'h0001, 16'h0000, 3'd2, 3'd2, 3'd5);
    @(posedge clock);
    #1;
    go_idle();
    @(negedge clock);
    drive(5'b10000, 1'b1, 1'b0, 16'hA5A5, 16'h0000, 3'd2, 3'd2, 3'd5);
    #1;
`ifdef WB_BYPASS_EN
    exp_byp = 16'hA5A5;
`else
    exp_byp = 16'h0001;
`endif
    check("bypass_same_cycle_rd1", bus.rd1, exp_byp);
    check("bypass_other_rd2", bus.rd2, 16'h1234);
    @(posedge clock);
    #1;
    go_idle();
    #1;
    check("bypass_after_edge_rd1", bus.rd1, 16'hA5A5);
    check("bypass_count", bus.wb_count, 16'd6);

    // Asynchronous reset between edges, then an edge while reset is held.
    @(negedge clock);
    drive(5'b10000, 1'b1, 1'b0, 16'h4242, 16'h0000, 3'd6, 3'd6, 3'd0);
    @(posedge clock);
    #1;
    go_idle();
    #1;
    check("pre_reset_valid", {15'd0, bus.wb_valid}, 16'd1);
    check("pre_reset_r6", bus.rd1, 16'h4242);
    reset = 1'b0;
    #1;
    check("async_reset_valid", {15'd0, bus.wb_valid}, 16'd0);
    check("async_reset_count", bus.wb_count, 16'd0);
    check("async_reset_r6", bus.rd1, 16'h0000);
    check("async_reset_r0", bus.rd2, 16'h0000);
    @(negedge clock);
    drive(5'b10000, 1'b1, 1'b0, 16'h7E7E, 16'h0000, 3'd6, 3'd6, 3'd0);
    @(posedge clock);
    #1;
    go_idle();
    #1;
    check("reset_hold_no_write", bus.rd1, 16'h0000);
    check("reset_hold_count", bus.wb_count, 16'd0);

    // Counter wrap: 65536 back-to-back commits.
    @(negedge clock);
    reset = 1'b1;
    drive(5'b10000, 1'b1, 1'b0, 16'h0F0F, 16'h0000, 3'd4, 3'd4, 3'd6);
    repeat (65535) @(posedge clock);
    #1;
    check("wrap_count_ffff", bus.wb_count, 16'hFFFF);
    check("wrap_valid_hi", {15'd0, bus.wb_valid}, 16'd1);
    @(posedge clock);
    #1;
    check("wrap_count_zero", bus.wb_count, 16'h0000);
    go_idle();
    #1;
    check("wrap_r4", bus.rd1, 16'h0F0F);
    check("wrap_r6", bus.rd2, 16'h0000);
    @(posedge clock);
    #1;
    check("wrap_valid_lo", {15'd0, bus.wb_valid}, 16'd0);
    check("wrap_count_hold", bus.wb_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
